// File: rtl/bus_arb_pkg.sv
// Shared types for the two-requester memory bus arbiter.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      DONE
   } arb_state_t;

   typedef enum logic {
      REQ_CPU,
      REQ_DMA
   } req_id_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2
   import bus_arb_pkg::*;
(
   input  logic [1:0] req,
   input  req_id_t    last_grant,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (last_grant == REQ_DMA) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one fixed-latency memory port between the CPU (req 0) and the DMA loader (req 1).
// Define BUS_ARB_MMIO_EN to serve IO_ADDR locally from SW/LEDR instead of memory.
//
// state  | meaning
// IDLE   | waiting for a request; picks a winner and latches its transaction
// ACCESS | one-cycle mem_en strobe (or local SW/LEDR access when MMIO is enabled)
// WAIT   | MEM_LAT-cycle down-count; read data captured on the terminal cycle
// DONE   | one-cycle ack to the granted requester
module mem_bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int              AW      = 16,
   parameter int              DW      = 16,
   parameter int              MEM_LAT = 2,
   parameter logic [AW-1:0]   IO_ADDR = 16'h2000
) (
   input  logic          clock,
   input  logic          reset_L,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_ack,
   output logic [DW-1:0] dma_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic [15:0]   SW,
   output logic [15:0]   LEDR
);

   localparam int CW = $clog2(MEM_LAT + 1);

   arb_state_t    state_q, state_d;
   req_id_t       last_grant_q, last_grant_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] dma_rdata_q, dma_rdata_d;
   logic [15:0]   ledr_q, ledr_d;
   logic [1:0]    gnt;
   logic          io_hit;

`ifdef BUS_ARB_MMIO_EN
   assign io_hit = (addr_q == IO_ADDR);
`else
   logic unused_io;
   assign io_hit    = 1'b0;
   assign unused_io = ^IO_ADDR;
`endif

   rr_arb2 u_rr_arb2 (
      .req        ({dma_req, cpu_req}),
      .last_grant (last_grant_q),
      .gnt        (gnt)
   );

   // last_grant_q doubles as the ID of the transaction in flight.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;
      cpu_rdata_d  = cpu_rdata_q;
      dma_rdata_d  = dma_rdata_q;
      ledr_d       = ledr_q;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      cpu_ack      = 1'b0;
      dma_ack      = 1'b0;
      case (state_q)
         IDLE: begin
            if (|gnt) begin
               state_d      = ACCESS;
               last_grant_d = gnt[0] ? REQ_CPU : REQ_DMA;
               we_d         = gnt[0] ? cpu_we : dma_we;
               addr_d       = gnt[0] ? cpu_addr : dma_addr;
               wdata_d      = gnt[0] ? cpu_wdata : dma_wdata;
            end
         end
         ACCESS: begin
            if (io_hit) begin
               if (we_q) ledr_d = 16'(wdata_q);
               else      rdata_d = DW'(SW);
               state_d = DONE;
            end else begin
               mem_en  = 1'b1;
               mem_we  = we_q;
               cnt_d   = CW'(MEM_LAT - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               rdata_d = mem_rdata;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            cpu_ack = (last_grant_q == REQ_CPU);
            dma_ack = (last_grant_q == REQ_DMA);
            if (cpu_ack) cpu_rdata_d = rdata_q;
            if (dma_ack) dma_rdata_d = rdata_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_L) begin
         state_q      <= IDLE;
         last_grant_q <= REQ_DMA;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         rdata_q      <= '0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
         ledr_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         rdata_q      <= rdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
         ledr_q       <= ledr_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_rdata = cpu_ack ? rdata_q : cpu_rdata_q;
   assign dma_rdata = dma_ack ? rdata_q : dma_rdata_q;
   assign LEDR      = ledr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a MEM_LAT=2 behavioural memory.
module tb_mem_bus_arbiter;

   logic        clock = 1'b0;
   logic        reset_L = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0, cpu_wdata = '0;
   logic        cpu_ack;
   logic [15:0] cpu_rdata;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [15:0] dma_addr = '0, dma_wdata = '0;
   logic        dma_ack;
   logic [15:0] dma_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = 16'hDEAD;
   logic [15:0] SW = '0;
   logic [15:0] LEDR;

   int checks = 0;
   int failures = 0;

   mem_bus_arbiter #(.AW(16), .DW(16), .MEM_LAT(2), .IO_ADDR(16'h2000)) dut (
      .clock(clock), .reset_L(reset_L),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .SW(SW), .LEDR(LEDR)
   );

   always #5 clock = ~clock;

   // Memory: writes on the strobe edge; read data valid only in the second cycle after mem_en.
   logic [15:0] mem_arr [logic [15:0]];
   logic        rd_v = 1'b0;
   logic [15:0] rd_d = '0;
   always @(posedge clock) begin
      if (mem_en && mem_we) mem_arr[mem_addr] = mem_wdata;
      rd_v      <= mem_en && !mem_we;
      rd_d      <= mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 16'h0000;
      mem_rdata <= rd_v ? rd_d : 16'hDEAD;
   end

   typedef logic        bitarr_t  [32];
   typedef logic [15:0] wordarr_t [32];
   bitarr_t  en_a, we_a, cack_a, dack_a;
   wordarr_t addr_a, wd_a, crd_a, drd_a, led_a;

   function automatic int first_hi(input bitarr_t a, input int from, input int to);
      for (int i = from; i < to; i++) if (a[i] === 1'b1) return i;
      return -1;
   endfunction

   function automatic int count_hi(input bitarr_t a, input int from, input int to);
      int n = 0;
      for (int i = from; i < to; i++) if (a[i] === 1'b1) n++;
      return n;
   endfunction

   // Samples cycles [from,to) at the falling edge; optionally drops req the cycle after its ack.
   task automatic run(input int from, input int to, input bit drop);
      for (int c = from; c < to; c++) begin
         @(negedge clock);
         en_a[c] = mem_en;   we_a[c] = mem_we;   addr_a[c] = mem_addr; wd_a[c] = mem_wdata;
         cack_a[c] = cpu_ack; dack_a[c] = dma_ack; crd_a[c] = cpu_rdata; drd_a[c] = dma_rdata;
         led_a[c] = LEDR;
         @(posedge clock); #1;
         if (drop && cack_a[c] === 1'b1) cpu_req = 1'b0;
         if (drop && dack_a[c] === 1'b1) dma_req = 1'b0;
      end
   endtask

   task automatic do_reset();
      reset_L = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_L = 1'b1;
   endtask

   task automatic test_reset();
      reset_L = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checks++; if (mem_en !== 1'b0)      begin failures++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
      checks++; if (mem_we !== 1'b0)      begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
      checks++; if (mem_addr !== 16'h0)   begin failures++; $display("FAIL rst_mem_addr got=%h exp=0000", mem_addr); end
      checks++; if (mem_wdata !== 16'h0)  begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0000", mem_wdata); end
      checks++; if ({cpu_ack, dma_ack} !== 2'b00) begin failures++; $display("FAIL rst_acks got=%b exp=00", {cpu_ack, dma_ack}); end
      checks++; if ({cpu_rdata, dma_rdata} !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", {cpu_rdata, dma_rdata}); end
      checks++; if (LEDR !== 16'h0)       begin failures++; $display("FAIL rst_ledr got=%h exp=0000", LEDR); end
      @(posedge clock); #1 reset_L = 1'b1;
   endtask

   task automatic test_cpu_read();
      do_reset();
      cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
      run(0, 8, 1'b1);
      checks++; if (first_hi(en_a, 0, 8) != 1) begin failures++; $display("FAIL rd_en_cycle got=%0d exp=1", first_hi(en_a, 0, 8)); end
      checks++; if (count_hi(en_a, 0, 8) != 1) begin failures++; $display("FAIL rd_en_count got=%0d exp=1", count_hi(en_a, 0, 8)); end
      checks++; if ({we_a[1], addr_a[1]} !== {1'b0, 16'h0010}) begin failures++; $display("FAIL rd_we_addr got=%b/%h exp=0/0010", we_a[1], addr_a[1]); end
      checks++; if (first_hi(cack_a, 0, 8) != 4) begin failures++; $display("FAIL rd_ack_cycle got=%0d exp=4", first_hi(cack_a, 0, 8)); end
      checks++; if (count_hi(cack_a, 0, 8) != 1) begin failures++; $display("FAIL rd_ack_count got=%0d exp=1", count_hi(cack_a, 0, 8)); end
      checks++; if (crd_a[4] !== 16'hBEEF) begin failures++; $display("FAIL rd_data got=%h exp=BEEF", crd_a[4]); end
      checks++; if (count_hi(dack_a, 0, 8) != 0) begin failures++; $display("FAIL rd_dma_ack got=%0d exp=0", count_hi(dack_a, 0, 8)); end
      checks++; if (crd_a[7] !== 16'hBEEF) begin failures++; $display("FAIL rd_data_hold got=%h exp=BEEF", crd_a[7]); end
   endtask

   task automatic test_dma_write();
      do_reset();
      dma_we = 1'b1; dma_addr = 16'h0100; dma_wdata = 16'h1234; dma_req = 1'b1;
      run(0, 1, 1'b1);
      dma_addr = 16'hFFFF; dma_wdata = 16'h0000; dma_we = 1'b0;
      run(1, 8, 1'b1);
      checks++; if (first_hi(en_a, 0, 8) != 1 || count_hi(en_a, 0, 8) != 1) begin failures++; $display("FAIL wr_en got=%0d/%0d exp=1/1", first_hi(en_a, 0, 8), count_hi(en_a, 0, 8)); end
      checks++; if ({we_a[1], addr_a[1], wd_a[1]} !== {1'b1, 16'h0100, 16'h1234}) begin failures++; $display("FAIL wr_bus got=%b/%h/%h exp=1/0100/1234", we_a[1], addr_a[1], wd_a[1]); end
      checks++; if (first_hi(dack_a, 0, 8) != 4) begin failures++; $display("FAIL wr_ack_cycle got=%0d exp=4", first_hi(dack_a, 0, 8)); end
      checks++; if (count_hi(cack_a, 0, 8) != 0) begin failures++; $display("FAIL wr_cpu_ack got=%0d exp=0", count_hi(cack_a, 0, 8)); end
   endtask

   task automatic test_back_to_back();
      reset_L = 1'b0;
      cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
      dma_we = 1'b0; dma_addr = 16'h0100; dma_req = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset_L = 1'b1;
      run(0, 20, 1'b0);
      cpu_req = 1'b0; dma_req = 1'b0;
      for (int c = 0; c < 20; c++) begin
         checks++; if (cack_a[c] === 1'b1 && dack_a[c] === 1'b1) begin failures++; $display("FAIL b2b_dual_ack cycle=%0d got=11 exp=not both", c); end
      end
      checks++; if ({cack_a[4], dack_a[9], cack_a[14], dack_a[19]} !== 4'b1111) begin failures++; $display("FAIL b2b_order got=%b exp=1111", {cack_a[4], dack_a[9], cack_a[14], dack_a[19]}); end
      checks++; if (count_hi(cack_a, 0, 20) != 2 || count_hi(dack_a, 0, 20) != 2) begin failures++; $display("FAIL b2b_counts got=%0d/%0d exp=2/2", count_hi(cack_a, 0, 20), count_hi(dack_a, 0, 20)); end
      checks++; if (count_hi(en_a, 0, 20) != 4) begin failures++; $display("FAIL b2b_en_count got=%0d exp=4", count_hi(en_a, 0, 20)); end
      checks++; if (crd_a[4] !== 16'hBEEF) begin failures++; $display("FAIL b2b_cpu_data got=%h exp=BEEF", crd_a[4]); end
      checks++; if (drd_a[9] !== 16'h1234) begin failures++; $display("FAIL b2b_dma_data got=%h exp=1234", drd_a[9]); end
      checks++; if (crd_a[9] !== 16'hBEEF) begin failures++; $display("FAIL b2b_cpu_hold got=%h exp=BEEF", crd_a[9]); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
      dma_we = 1'b0; dma_addr = 16'h0100;
      run(0, 2, 1'b1);
      reset_L = 1'b0; dma_req = 1'b1;
      run(2, 4, 1'b1);
      reset_L = 1'b1;
      run(4, 12, 1'b1);
      dma_req = 1'b0;
      checks++; if ({en_a[3], cack_a[3]} !== 2'b00) begin failures++; $display("FAIL rmid_after_rst got=%b exp=00", {en_a[3], cack_a[3]}); end
      checks++; if (cack_a[4] !== 1'b0) begin failures++; $display("FAIL rmid_aborted_ack got=%b exp=0", cack_a[4]); end
      checks++; if (first_hi(cack_a, 0, 12) != 8 || count_hi(cack_a, 0, 12) != 1) begin failures++; $display("FAIL rmid_cpu_wins got=%0d/%0d exp=8/1", first_hi(cack_a, 0, 12), count_hi(cack_a, 0, 12)); end
      checks++; if (count_hi(dack_a, 0, 12) != 0) begin failures++; $display("FAIL rmid_dma_ack got=%0d exp=0", count_hi(dack_a, 0, 12)); end
      checks++; if (count_hi(en_a, 0, 12) != 3) begin failures++; $display("FAIL rmid_en_count got=%0d exp=3", count_hi(en_a, 0, 12)); end
      checks++; if (crd_a[8] !== 16'hBEEF) begin failures++; $display("FAIL rmid_data got=%h exp=BEEF", crd_a[8]); end
   endtask

`ifdef BUS_ARB_MMIO_EN
   task automatic test_mmio();
      do_reset();
      SW = 16'hA5A5; cpu_we = 1'b0; cpu_addr = 16'h2000; cpu_req = 1'b1;
      run(0, 4, 1'b1);
      checks++; if (count_hi(en_a, 0, 4) != 0) begin failures++; $display("FAIL io_rd_en got=%0d exp=0", count_hi(en_a, 0, 4)); end
      checks++; if (first_hi(cack_a, 0, 4) != 2) begin failures++; $display("FAIL io_rd_ack got=%0d exp=2", first_hi(cack_a, 0, 4)); end
      checks++; if (crd_a[2] !== 16'hA5A5) begin failures++; $display("FAIL io_rd_data got=%h exp=A5A5", crd_a[2]); end
      cpu_we = 1'b1; cpu_wdata = 16'h00FF; cpu_req = 1'b1;
      run(0, 5, 1'b1);
      checks++; if (count_hi(en_a, 0, 5) != 0) begin failures++; $display("FAIL io_wr_en got=%0d exp=0", count_hi(en_a, 0, 5)); end
      checks++; if (first_hi(cack_a, 0, 5) != 2) begin failures++; $display("FAIL io_wr_ack got=%0d exp=2", first_hi(cack_a, 0, 5)); end
      checks++; if ({led_a[1], led_a[2], led_a[4]} !== {16'h0000, 16'h00FF, 16'h00FF}) begin failures++; $display("FAIL io_ledr got=%h/%h/%h exp=0000/00FF/00FF", led_a[1], led_a[2], led_a[4]); end
   endtask
`else
   task automatic test_mmio();
      do_reset();
      SW = 16'hA5A5; cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 16'h00FF; cpu_req = 1'b1;
      run(0, 7, 1'b1);
      checks++; if (first_hi(en_a, 0, 7) != 1 || count_hi(en_a, 0, 7) != 1) begin failures++; $display("FAIL nio_en got=%0d/%0d exp=1/1", first_hi(en_a, 0, 7), count_hi(en_a, 0, 7)); end
      checks++; if ({we_a[1], addr_a[1]} !== {1'b1, 16'h2000}) begin failures++; $display("FAIL nio_bus got=%b/%h exp=1/2000", we_a[1], addr_a[1]); end
      checks++; if (first_hi(cack_a, 0, 7) != 4) begin failures++; $display("FAIL nio_ack got=%0d exp=4", first_hi(cack_a, 0, 7)); end
      for (int c = 0; c < 7; c++) begin
         checks++; if (led_a[c] !== 16'h0000) begin failures++; $display("FAIL nio_ledr cycle=%0d got=%h exp=0000", c, led_a[c]); end
      end
      cpu_we = 1'b0; cpu_req = 1'b1;
      run(0, 6, 1'b1);
      checks++; if (first_hi(cack_a, 0, 6) != 4) begin failures++; $display("FAIL nio_rd_ack got=%0d exp=4", first_hi(cack_a, 0, 6)); end
      checks++; if (crd_a[4] !== 16'h00FF) begin failures++; $display("FAIL nio_rd_data got=%h exp=00FF", crd_a[4]); end
   endtask
`endif

   initial begin
      mem_arr[16'h0010] = 16'hBEEF;
      test_reset();
      test_cpu_read();
      test_dma_write();
      test_back_to_back();
      test_reset_mid();
      test_mmio();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
